// File: rtl/calc_operand_engine.sv
// Operand/opcode capture and arithmetic engine for the DE10-Lite calculator.
// Strobes from the key-stage controller latch operands and start ADD/SUB/MUL/DIV.
module calc_operand_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               write,
  input  logic [1:0]         stage,
  input  logic [WIDTH-1:0]   sw,
  output logic [WIDTH-1:0]   opA,
  output logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic             write_q;
  logic             strobe;
  logic             act;
  logic             start;
  logic             clr;
  logic             fin;
  logic             div0;

  logic [1:0]       op;
  logic [WIDTH-1:0] wa;
  logic [WIDTH-1:0] wb;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;

  // Rising edge of write; strobes during an operation are dropped entirely
  assign strobe = write & ~write_q;
  assign act    = strobe & (state != CALC);
  assign start  = act & (stage == 2'd2);
  assign clr    = act & (stage == 2'd3);

  assign div0  = (op == OP_DIV) && (wb == '0);
  // Restoring-divide trial: partial remainder shifted left by one, minus divisor
  assign trial = acc[RW-1:WIDTH-1] - {1'b0, wb};

  always_comb begin
    fin = 1'b1;
    if ((op == OP_MUL) || ((op == OP_DIV) && !div0)) begin
      fin = (cnt == CW'(WIDTH));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_q <= 1'b0;
    end else begin
      write_q <= write;
    end
  end

  // FSM state register; busy/done are registered decodes of the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (fin) state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt = CALC;
        end else if (clr) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == CALC) busy_nxt = 1'b1;
    if (state_nxt == DONE) done_nxt = 1'b1;
  end

  // Operand capture, working registers and iterative datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opA    <= '0;
      opB    <= '0;
      result <= '0;
      err    <= 1'b0;
      op     <= OP_ADD;
      wa     <= '0;
      wb     <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else if (act) begin
      unique case (stage)
        2'd0: opA <= sw;
        2'd1: opB <= sw;
        2'd2: begin
          op    <= sw[1:0];
          wa    <= opA;
          wb    <= opB;
          mcand <= RW'(opA);
          acc   <= (sw[1:0] == OP_DIV) ? RW'(opA) : '0;
          cnt   <= '0;
          err   <= 1'b0;
        end
        2'd3: begin
          opA    <= '0;
          opB    <= '0;
          result <= '0;
          err    <= 1'b0;
        end
        default: ;
      endcase
    end else if (state == CALC) begin
      if (fin) begin
        unique case (op)
          OP_ADD: result <= RW'(wa) + RW'(wb);
          OP_SUB: result <= RW'(wa) - RW'(wb);
          OP_MUL: result <= acc;
          OP_DIV: result <= div0 ? '1 : acc;
          default: ;
        endcase
        err <= div0;
      end else begin
        cnt <= cnt + CW'(1);
        if (op == OP_MUL) begin
          if (wb[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          wb    <= wb >> 1;
        end else if (!trial[WIDTH]) begin
          acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
          acc <= {acc[RW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_operand_engine.sv
// Scoreboard bench for calc_operand_engine: directed cases plus random operations
// checked against a plain-arithmetic reference model.
module tb_calc_operand_engine;

  logic        CLK;
  logic        RST;
  logic        write;
  logic [1:0]  stage;
  logic [7:0]  sw;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        err;

  calc_operand_engine #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .write(write), .stage(stage), .sw(sw),
    .opA(opA), .opB(opB), .result(result), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   busy_cnt = 0;
  logic done_prev = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    e.err = 1'b0;
    e.lat = 1;
    e.start = 0;
    case (op)
      0: e.res = 16'(a + b);
      1: e.res = 16'(a - b);
      2: begin e.res = 16'(a * b); e.lat = 9; end
      default: begin
        if (b == 0) begin
          e.res = 16'hFFFF;
          e.err = 1'b1;
        end else begin
          e.res = 16'(((a % b) << 8) | (a / b));
          e.lat = 9;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: on every completion compare against the oldest outstanding operation
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      busy_cnt = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic strobe(input logic [1:0] s, input logic [7:0] v);
    @(posedge CLK) #1;
    write = 1'b1;
    stage = s;
    sw = v;
    @(posedge CLK) #1;
    write = 1'b0;
  endtask

  // Start edge is the one where write is first seen high
  task automatic start_op(input int a, input int b, input int op);
    exp_t e;
    e = model(a, b, op);
    @(posedge CLK) #1;
    write = 1'b1;
    stage = 2'd2;
    sw = {6'($urandom_range(0, 63)), 2'(op)};
    @(posedge CLK) #1;
    e.start = cyc;
    sb.push_back(e);
    write = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done && !busy) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic calc(input int a, input int b, input int op);
    strobe(2'd0, 8'(a));
    strobe(2'd1, 8'(b));
    chk("opA_capture", 32'(opA), 32'(a));
    chk("opB_capture", 32'(opB), 32'(b));
    start_op(a, b, op);
    wait_done();
  endtask

  initial begin
    RST = 1'b1;
    write = 1'b0;
    stage = 2'd0;
    sw = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_opA", 32'(opA), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'({busy, done, err}), 32'(0));
    RST = 1'b0;

    calc(12, 5, 0);
    calc(5, 12, 1);
    calc(255, 255, 2);
    calc(100, 7, 3);
    calc(100, 0, 3);
    calc(0, 0, 2);
    calc(255, 1, 3);

    // Held write level: only the first edge captures
    @(posedge CLK) #1;
    write = 1'b1;
    stage = 2'd0;
    sw = 8'h3C;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK) #1;
      sw = 8'(8'h3C + i);
    end
    write = 1'b0;
    chk("hold_opA", 32'(opA), 32'h3C);

    // Capture attempt during a running multiply is ignored
    strobe(2'd0, 8'd10);
    strobe(2'd1, 8'd20);
    start_op(10, 20, 2);
    strobe(2'd0, 8'd99);
    chk("busy_strobe_busy", 32'(busy), 32'(1));
    wait_done();
    chk("busy_strobe_opA", 32'(opA), 32'd10);

    // Asynchronous reset in the middle of a multiply
    strobe(2'd0, 8'd7);
    strobe(2'd1, 8'd9);
    start_op(7, 9, 2);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_opA", 32'(opA), 32'(0));
    chk("arst_opB", 32'(opB), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_flags", 32'({busy, done, err}), 32'(0));
    sb.delete();
    @(posedge CLK) #1;
    RST = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    chk("post_rst_idle", 32'({busy, done}), 32'(0));

    // Stage-3 clear after completion
    calc(3, 4, 0);
    strobe(2'd3, 8'hFF);
    chk("clr_opA", 32'(opA), 32'(0));
    chk("clr_opB", 32'(opB), 32'(0));
    chk("clr_result", 32'(result), 32'(0));
    chk("clr_done", 32'(done), 32'(0));

    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      int op;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        strobe(2'd3, 8'($urandom));
        chk("rand_clr_result", 32'(result), 32'(0));
      end
      calc(a, b, op);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
